// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, palette and colour-bar table.
// The bar table is only selected by builds with TEST_PATTERN_EN.
package vga_pkg;

   localparam int VGA_CLK_DIV     = 4;
   localparam int VGA_H_TOTAL     = 800;
   localparam int VGA_H_SYNC      = 96;
   localparam int VGA_H_VIS_START = 144;
   localparam int VGA_H_VIS_END   = 783;
   localparam int VGA_V_TOTAL     = 525;
   localparam int VGA_V_SYNC      = 2;
   localparam int VGA_V_VIS_START = 35;
   localparam int VGA_V_VIS_END   = 514;
   localparam int VGA_MOVE_DIV    = 4;
   localparam int BAR_W           = 80;

   localparam logic [11:0] WHITE   = 12'hFFF;
   localparam logic [11:0] YELLOW  = 12'hFF0;
   localparam logic [11:0] CYAN    = 12'h0FF;
   localparam logic [11:0] GREEN   = 12'h0F0;
   localparam logic [11:0] MAGENTA = 12'hF0F;
   localparam logic [11:0] RED     = 12'hF00;
   localparam logic [11:0] BLUE    = 12'h00F;
   localparam logic [11:0] BLACK   = 12'h000;

   localparam logic [11:0] BAR_TBL [8] = '{
      WHITE, YELLOW, CYAN, GREEN,
      MAGENTA, RED, BLUE, BLACK
   };

   // off is the column relative to the first visible pixel
   function automatic logic [11:0] bar_color(input logic [9:0] off);
      return BAR_TBL[3'(off / 10'(BAR_W))];
   endfunction

endpackage

// File: rtl/vga_display_driver_if.sv
// Raster/colour bundle between the sprite logic and the VGA driver.
// master = driver side, slave = sprite/maze side.
interface vga_display_driver_if;

   logic        pacmanFill;
   logic        ghostFill;
   logic        wallFill;
   logic        pelletFill;
   logic        test_pat;
   logic [9:0]  hCount;
   logic [9:0]  vCount;
   logic        bright;
   logic        hSync;
   logic        vSync;
   logic [11:0] rgb;
   logic        frame_tick;
   logic        move_tick;

   modport master (
      input  pacmanFill, ghostFill, wallFill, pelletFill, test_pat,
      output hCount, vCount, bright, hSync, vSync, rgb,
      output frame_tick, move_tick
   );

   modport slave (
      output pacmanFill, ghostFill, wallFill, pelletFill, test_pat,
      input  hCount, vCount, bright, hSync, vSync, rgb,
      input  frame_tick, move_tick
   );

endinterface

// File: rtl/pix_tick_gen.sv
// Pixel-enable generator: one-clk pulse every CLK_DIV system clocks.
module pix_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic pix_en
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_q, div_d;

   assign pix_en = (div_q == D_LAST);

   always_comb begin
      div_d = div_q + 1'b1;
      if (pix_en) div_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) div_q <= '0;
      else       div_q <= div_d;
   end

endmodule

// File: rtl/vga_display_driver.sv
// 640x480@60 raster timing, fill-priority colour mux and frame/move strobes.
// Define TEST_PATTERN_EN to let test_pat select eight colour bars.
module vga_display_driver
   import vga_pkg::*;
#(
   parameter int CLK_DIV     = VGA_CLK_DIV,
   parameter int H_TOTAL     = VGA_H_TOTAL,
   parameter int H_SYNC      = VGA_H_SYNC,
   parameter int H_VIS_START = VGA_H_VIS_START,
   parameter int H_VIS_END   = VGA_H_VIS_END,
   parameter int V_TOTAL     = VGA_V_TOTAL,
   parameter int V_SYNC      = VGA_V_SYNC,
   parameter int V_VIS_START = VGA_V_VIS_START,
   parameter int V_VIS_END   = VGA_V_VIS_END,
   parameter int MOVE_DIV    = VGA_MOVE_DIV
) (
   input  logic clk,
   input  logic reset,
   vga_display_driver_if.master vif
);

`ifdef TEST_PATTERN_EN
   localparam bit TP_EN = 1'b1;
`else
   localparam bit TP_EN = 1'b0;
`endif

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] HS_W   = 10'(H_SYNC);
   localparam logic [9:0] VS_W   = 10'(V_SYNC);
   localparam logic [9:0] HV0    = 10'(H_VIS_START);
   localparam logic [9:0] HV1    = 10'(H_VIS_END);
   localparam logic [9:0] VV0    = 10'(V_VIS_START);
   localparam logic [9:0] VV1    = 10'(V_VIS_END);
   localparam int FW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam logic [FW-1:0] F_LAST = FW'(MOVE_DIV - 1);

   logic          pix_en;
   logic [9:0]    h_q, h_d, v_q, v_d;
   logic [FW-1:0] f_q, f_d;
   logic          hs_q, vs_q, ft_q, mt_q;
   logic [11:0]   rgb_q, rgb_d, fill_rgb;
   logic          bright, h_wrap, frame_wrap;

   pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_pix (
      .clk    (clk),
      .reset  (reset),
      .pix_en (pix_en)
   );

   assign h_wrap     = (h_q == H_LAST);
   assign frame_wrap = pix_en && h_wrap && (v_q == V_LAST);
   assign bright     = (h_q >= HV0) && (h_q <= HV1) &&
                       (v_q >= VV0) && (v_q <= VV1);

   always_comb begin
      h_d = h_q;
      v_d = v_q;
      f_d = f_q;
      if (pix_en) begin
         h_d = h_wrap ? '0 : h_q + 10'd1;
         if (h_wrap) v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end
      if (frame_wrap) f_d = (f_q == F_LAST) ? '0 : f_q + 1'b1;
   end

   always_comb begin
      fill_rgb = BLACK;
      priority case (1'b1)
         vif.pacmanFill: fill_rgb = YELLOW;
         vif.ghostFill:  fill_rgb = RED;
         vif.wallFill:   fill_rgb = BLUE;
         vif.pelletFill: fill_rgb = WHITE;
         default:        fill_rgb = BLACK;
      endcase
   end

   // colour bars override fills only inside the visible window
   always_comb begin
      rgb_d = BLACK;
      if (bright) begin
         if (TP_EN && vif.test_pat) rgb_d = bar_color(h_q - HV0);
         else                       rgb_d = fill_rgb;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h_q   <= '0;
         v_q   <= '0;
         f_q   <= '0;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
         rgb_q <= '0;
         ft_q  <= 1'b0;
         mt_q  <= 1'b0;
      end else begin
         h_q  <= h_d;
         v_q  <= v_d;
         f_q  <= f_d;
         ft_q <= frame_wrap;
         mt_q <= frame_wrap && (f_q == F_LAST);
         if (pix_en) begin
            hs_q  <= (h_q >= HS_W);
            vs_q  <= (v_q >= VS_W);
            rgb_q <= rgb_d;
         end
      end
   end

   assign vif.hCount     = h_q;
   assign vif.vCount     = v_q;
   assign vif.bright     = bright;
   assign vif.hSync      = hs_q;
   assign vif.vSync      = vs_q;
   assign vif.rgb        = rgb_q;
   assign vif.frame_tick = ft_q;
   assign vif.move_tick  = mt_q;

endmodule

// File: tb/tb_vga_display_driver.sv
// Bench: full-size instance for line timing, shrunken instance for
// window, priority, frame/move strobes and mid-frame reset.
module tb_vga_display_driver;

   logic clk = 1'b0;
   logic reset_b = 1'b1;
   logic reset_s = 1'b1;

   always #5 clk = ~clk;

   vga_display_driver_if vif_b ();
   vga_display_driver_if vif_s ();

   vga_display_driver u_big (
      .clk   (clk),
      .reset (reset_b),
      .vif   (vif_b)
   );

   // small raster: 20x8 pixels, visible h 5..16, v 2..6
   vga_display_driver #(
      .CLK_DIV(4), .H_TOTAL(20), .H_SYNC(3),
      .H_VIS_START(5), .H_VIS_END(16),
      .V_TOTAL(8), .V_SYNC(2),
      .V_VIS_START(2), .V_VIS_END(6), .MOVE_DIV(4)
   ) u_small (
      .clk   (clk),
      .reset (reset_s),
      .vif   (vif_s)
   );

   int n_chk = 0;
   int n_err = 0;
   logic [11:0] sb_q [$];

   typedef struct {
      int          h;
      int          v;
      logic [3:0]  f;
      logic        b;
      logic [11:0] rgb;
   } vec_t;

   vec_t tbl [12];

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic wait_pos(input int h, input int v);
      int n;
      n = 0;
      while (!(int'(vif_s.hCount) == h && int'(vif_s.vCount) == v)
             && n < 800) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("reach_%0d_%0d", h, v),
            int'(int'(vif_s.hCount) == h && int'(vif_s.vCount) == v), 1);
   endtask

   task automatic wait_move();
      logic [9:0] h0;
      int n;
      h0 = vif_s.hCount;
      n = 0;
      while (vif_s.hCount == h0 && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("pix_advance", int'(vif_s.hCount != h0), 1);
   endtask

   task automatic set_fills(input logic [3:0] f);
      vif_s.pacmanFill = f[3];
      vif_s.ghostFill  = f[2];
      vif_s.wallFill   = f[1];
      vif_s.pelletFill = f[0];
   endtask

   initial begin
      int h, v, prev_h, prev_v, last_chg, first_chg, per_err;
      int max_h, wrap_seen, wrap_ok, fall1, rise1, fall2;
      int vs_low, nft, nmt, ft_err, mt_err;
      logic prev_hs;
      logic [11:0] exp_rgb;

      tbl[0]  = '{10, 1, 4'b1000, 1'b0, 12'h000};
      tbl[1]  = '{ 4, 2, 4'b1000, 1'b0, 12'h000};
      tbl[2]  = '{ 5, 2, 4'b1000, 1'b1, 12'hFF0};
      tbl[3]  = '{10, 3, 4'b1111, 1'b1, 12'hFF0};
      tbl[4]  = '{11, 3, 4'b0111, 1'b1, 12'hF00};
      tbl[5]  = '{12, 3, 4'b0011, 1'b1, 12'h00F};
      tbl[6]  = '{13, 3, 4'b0001, 1'b1, 12'hFFF};
      tbl[7]  = '{14, 3, 4'b0000, 1'b1, 12'h000};
      tbl[8]  = '{15, 3, 4'b0101, 1'b1, 12'hF00};
      tbl[9]  = '{16, 6, 4'b1000, 1'b1, 12'hFF0};
      tbl[10] = '{17, 6, 4'b1000, 1'b0, 12'h000};
      tbl[11] = '{10, 7, 4'b1111, 1'b0, 12'h000};

      vif_b.pacmanFill = 1'b0;
      vif_b.ghostFill  = 1'b0;
      vif_b.wallFill   = 1'b0;
      vif_b.pelletFill = 1'b0;
      vif_b.test_pat   = 1'b0;
      vif_s.test_pat   = 1'b0;
      set_fills(4'b0000);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_hCount", int'(vif_b.hCount), 0);
      check("rst_vCount", int'(vif_b.vCount), 0);
      check("rst_hSync", int'(vif_b.hSync), 1);
      check("rst_vSync", int'(vif_b.vSync), 1);
      check("rst_rgb", int'(vif_b.rgb), 0);
      check("rst_frame_tick", int'(vif_b.frame_tick), 0);
      check("rst_move_tick", int'(vif_b.move_tick), 0);
      reset_b = 1'b0;
      reset_s = 1'b0;

      // full-size line timing and hSync widths
      prev_h = 0; prev_v = 0; last_chg = 0; first_chg = -1;
      per_err = 0; max_h = 0; wrap_seen = 0; wrap_ok = 0;
      fall1 = -1; rise1 = -1; fall2 = -1; prev_hs = 1'b1;
      for (int cyc = 1; cyc <= 3400; cyc++) begin
         @(negedge clk);
         h = int'(vif_b.hCount);
         v = int'(vif_b.vCount);
         if (h != prev_h) begin
            if (first_chg < 0) first_chg = cyc;
            else if (cyc - last_chg != 4) per_err++;
            last_chg = cyc;
            if (prev_h == 799 && h == 0) begin
               wrap_seen++;
               if (prev_v == 0 && v == 1) wrap_ok++;
            end
         end
         if (h > max_h) max_h = h;
         if (prev_hs && !vif_b.hSync) begin
            if (fall1 < 0) fall1 = cyc;
            else if (fall2 < 0) fall2 = cyc;
         end
         if (!prev_hs && vif_b.hSync && rise1 < 0) rise1 = cyc;
         prev_h = h;
         prev_v = v;
         prev_hs = vif_b.hSync;
      end
      check("first_pix_en", first_chg, 4);
      check("pix_period_errs", per_err, 0);
      check("hCount_max", max_h, 799);
      check("line_wraps", wrap_seen, 1);
      check("v_step_at_wrap", wrap_ok, 1);
      check("hSync_low_clks", rise1 - fall1, 384);
      check("hSync_high_clks", fall2 - rise1, 2816);

      // window and priority through the rgb scoreboard
      foreach (tbl[i]) begin
         wait_pos(tbl[i].h, tbl[i].v);
         check($sformatf("bright_%0d", i), int'(vif_s.bright),
               int'(tbl[i].b));
         set_fills(tbl[i].f);
         sb_q.push_back(tbl[i].rgb);
         wait_move();
         exp_rgb = sb_q.pop_front();
         check($sformatf("rgb_%0d", i), int'(vif_s.rgb), int'(exp_rgb));
      end

      // mid-frame reset with a lit pixel in flight
      set_fills(4'b1000);
      wait_pos(10, 4);
      wait_move();
      check("pre_rst_rgb", int'(vif_s.rgb), 12'hFF0);
      reset_s = 1'b1;
      @(negedge clk);
      reset_s = 1'b0;
      set_fills(4'b0000);
      check("mid_rst_hCount", int'(vif_s.hCount), 0);
      check("mid_rst_vCount", int'(vif_s.vCount), 0);
      check("mid_rst_hSync", int'(vif_s.hSync), 1);
      check("mid_rst_vSync", int'(vif_s.vSync), 1);
      check("mid_rst_rgb", int'(vif_s.rgb), 0);

      // resumed timing, vSync width and frame/move strobes
      prev_h = 0; first_chg = -1; vs_low = 0;
      nft = 0; nmt = 0; ft_err = 0; mt_err = 0;
      for (int cyc = 1; cyc <= 5200; cyc++) begin
         @(negedge clk);
         h = int'(vif_s.hCount);
         if (h != prev_h && first_chg < 0) first_chg = cyc;
         prev_h = h;
         if (cyc <= 640 && !vif_s.vSync) vs_low++;
         if (vif_s.frame_tick) begin
            nft++;
            if (cyc != nft * 640) ft_err++;
            if (vif_s.move_tick != ((nft % 4) == 0)) mt_err++;
         end else if (vif_s.move_tick) begin
            mt_err++;
         end
         if (vif_s.move_tick) nmt++;
      end
      check("resume_first_pix", first_chg, 4);
      check("vSync_low_clks", vs_low, 160);
      check("frame_tick_count", nft, 8);
      check("frame_tick_timing", ft_err, 0);
      check("move_tick_align", mt_err, 0);
      check("move_tick_count", nmt, 2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
